ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters SHALL be:
- AWIDTH, default 32, address width.
- DWIDTH, default 32, instruction width.
- BASEADDR, default 32'h01000000, reset PC.
- DEPTH, default 4, queue entries (power of two, at least 2).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- imem_req_o, out, 1, fetch request to instruction memory.
- imem_addr_o, out, AWIDTH, request address.
- imem_gnt_i, in, 1, request accepted this cycle.
- imem_rvalid_i, in, 1, response valid.
- imem_rdata_i, in, DWIDTH, response instruction.
- redirect_i, in, 1, flush and restart from redirect_pc_i.
- redirect_pc_i, in, AWIDTH, new fetch PC.
- insn_valid_o, out, 1, head entry valid to decode.
- insn_ready_i, in, 1, decode accepts head entry.
- insn_o, out, DWIDTH, head instruction.
- pc_o, out, AWIDTH, head PC.

Function
REQ-003 A request SHALL transfer on a cycle where imem_req_o and imem_gnt_i are both 1.
REQ-004 On each transfer, fetch_pc SHALL advance by 4, with modulo 2^AWIDTH wrap.
REQ-005 imem_addr_o SHALL equal fetch_pc and SHALL hold stable while imem_req_o=1 and imem_gnt_i=0.
REQ-006 imem_req_o SHALL be 1 only when all of the following hold:
- (occupancy + outstanding) < DEPTH;
- redirect_i=0;
- drop_cnt=0.
REQ-007 Responses SHALL arrive in order, at most one per cycle, no earlier than the cycle after their grant.
REQ-008 A non-dropped response SHALL be pushed as {resp_pc, imem_rdata_i}, and resp_pc SHALL then advance by 4.
REQ-009 insn_valid_o SHALL be 1 when occupancy > 0; insn_o and pc_o SHALL show the head entry, or all zeros when empty.
REQ-010 The head entry SHALL pop on insn_valid_o && insn_ready_i; push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-011 A push while full SHALL be impossible by the REQ-006 credit rule; the design SHALL carry an assertion for it.
REQ-012 Pass-through SHALL NOT exist: a response pushed in cycle N SHALL be visible on insn_o no earlier than cycle N+1.
REQ-013 When redirect_i=1, at the next edge:
- the queue SHALL empty;
- fetch_pc and resp_pc SHALL load {redirect_pc_i[AWIDTH-1:2], 2'b00};
- drop_cnt SHALL load the count of outstanding requests not yet answered; a response arriving in the redirect cycle SHALL itself be discarded and SHALL not be counted.
REQ-014 When redirect_i=1, any pop or push in that same cycle SHALL be void.
REQ-015 While drop_cnt>0, each response SHALL decrement drop_cnt and SHALL NOT be enqueued or advance resp_pc.
REQ-016 A redirect arriving while drop_cnt>0 SHALL recompute drop_cnt per REQ-013.
REQ-017 A response while outstanding=0 and drop_cnt=0 SHALL be ignored and SHALL fire an assertion.
REQ-018 The occupancy, outstanding and drop_cnt counters SHALL each be $clog2(DEPTH)+1 bits wide.

Reset
REQ-019 While rst=0 the block SHALL asynchronously clear to the following state:
- imem_req_o=0 and insn_valid_o=0;
- insn_o=0 and pc_o=0;
- occupancy, outstanding and drop_cnt = 0;
- fetch_pc = resp_pc = BASEADDR.
REQ-020 In the first cycle after rst rises, imem_req_o SHALL be 1 with imem_addr_o=BASEADDR.
REQ-021 Reset in mid-operation SHALL abandon all in-flight requests; the memory is reset by the same rst.

Structure
REQ-022 Package ifetch_pkg SHALL hold:
- BASEADDR_DEFAULT and DEPTH_DEFAULT;
- INSN_NOP = 32'h00000013;
- typedef fetch_entry_t {pc, insn}.
REQ-023 Storage SHALL be a sub-module ifetch_fifo (sync FIFO of fetch_entry_t, DEPTH entries, push/pop/full/empty/count). The credit, drop and PC logic SHALL stay in ifetch_queue.

Verification
REQ-024 Reset release with imem_gnt_i=1 and 1-cycle response latency, insn_ready_i=1 -> addresses 0x01000000, 0x01000004, 0x01000008 are issued on consecutive cycles, and pc_o follows the same sequence with insn_o matching memory.
REQ-025 insn_ready_i=0 for 10 cycles -> exactly 4 grants occur, then imem_req_o=0 and the queue holds 4 entries. On ready=1, one entry pops per cycle in PC order and requests resume.
REQ-026 Redirect to 0x01000102 with 2 requests outstanding -> next fetch address is 0x01000100, the 2 late responses are dropped, and the first valid output is pc_o=0x01000100.
REQ-027 Redirect in the same cycle as a response and a pop -> the response is discarded, occupancy is 0 next cycle, and drop_cnt excludes that response.
REQ-028 imem_gnt_i held at 0 for 5 cycles -> imem_addr_o stays stable and fetch_pc does not advance.
REQ-029 rst asserted mid-stream with 3 entries queued -> outputs clear immediately, and after release the first request is to 0x01000000.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared defaults and entry type for the instruction fetch queue
package ifetch_pkg;
    localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;
    localparam int DEPTH_DEFAULT = 4;
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch entries with single-cycle flush
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= din;
    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-limited instruction prefetch with redirect flush and stale-response dropping
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT),
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [AWIDTH-1:0] fetch_pc, resp_pc, redir_pc;
    logic [CW-1:0] occ, out_cnt, drop_cnt;
    logic xfer, rsp, push, pop, empty, full;
    fetch_entry_t head, entry;
    assign redir_pc     = redirect_pc_i & ~AWIDTH'(3);
    assign rsp          = imem_rvalid_i && out_cnt != '0;
    assign imem_req_o   = rst && !redirect_i && drop_cnt == '0 &&
                          ({1'b0, occ} + {1'b0, out_cnt} < (CW+1)'(DEPTH));
    assign imem_addr_o  = fetch_pc;
    assign xfer         = imem_req_o && imem_gnt_i;
    assign push         = rsp && !redirect_i && drop_cnt == '0;
    assign pop          = insn_valid_o && insn_ready_i && !redirect_i;
    assign insn_valid_o = !empty;
    assign insn_o       = empty ? '0 : DWIDTH'(head.insn);
    assign pc_o         = empty ? '0 : AWIDTH'(head.pc);
    assign entry        = '{pc: 32'(resp_pc), insn: 32'(imem_rdata_i)};
    // out_cnt tracks every request still in flight; the oldest drop_cnt of them are stale
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            fetch_pc <= BASEADDR;
            resp_pc  <= BASEADDR;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redir_pc;
            resp_pc  <= redir_pc;
            out_cnt  <= out_cnt - CW'(rsp);
            drop_cnt <= out_cnt - CW'(rsp);
        end else begin
            if (xfer) fetch_pc <= fetch_pc + AWIDTH'(4);
            if (push) resp_pc <= resp_pc + AWIDTH'(4);
            out_cnt <= out_cnt + CW'(xfer) - CW'(rsp);
            if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(redirect_i), .push(push), .pop(pop),
        .din(entry), .dout(head), .full(full), .empty(empty), .count(occ)
    );
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid_i && out_cnt == '0 && drop_cnt == '0));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized scoreboard bench with an address-tagged memory model
module tb_ifetch_queue;
    import ifetch_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 0;
    logic imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, insn_valid_o, insn_ready_i;
    logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, insn_o, pc_o;

    ifetch_queue dut (
        .clk(clk), .rst(rst), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .insn_valid_o(insn_valid_o),
        .insn_ready_i(insn_ready_i), .insn_o(insn_o), .pc_o(pc_o)
    );
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
    req_t pend[$];
    exp_t sb[$];
    int epoch, cyc, n_chk, n_pass;
    int p_gnt, p_rdy, p_rsp, p_redir, max_lat;
    bit run;
    logic [31:0] exp_fetch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: compares the head against the oldest expected entry and retires it on handshake
    always @(negedge clk) if (run) begin
        #2;
        chk("insn_valid", 32'(insn_valid_o), 32'(sb.size() != 0));
        if (sb.size() == 0) begin
            chk("insn_idle", insn_o, 32'h0);
            chk("pc_idle", pc_o, 32'h0);
        end else begin
            chk("pc", pc_o, sb[0].pc);
            chk("insn", insn_o, sb[0].insn);
            if (insn_ready_i && !redirect_i) void'(sb.pop_front());
        end
    end

    task automatic step(input bit fr);
        int junk = 0;
        bit rsp_ok;
        req_t r;
        @(negedge clk);
        cyc++;
        redirect_i    = fr || ($urandom_range(99) < p_redir);
        redirect_pc_i = fr ? 32'h0100_0102 :
                        ($urandom_range(9) == 0) ? 32'hFFFF_FFF6 : BASEADDR_DEFAULT + $urandom_range(255);
        imem_gnt_i    = $urandom_range(99) < p_gnt;
        insn_ready_i  = $urandom_range(99) < p_rdy;
        rsp_ok        = pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < p_rsp;
        imem_rvalid_i = rsp_ok;
        imem_rdata_i  = rsp_ok ? pend[0].data : 32'h0;
        #1;
        foreach (pend[i]) if (pend[i].epoch != epoch) junk++;
        chk("imem_req", 32'(imem_req_o),
            32'(!redirect_i && junk == 0 && sb.size() + pend.size() < DEPTH));
        if (imem_req_o) chk("imem_addr", imem_addr_o, exp_fetch);
        #2;
        if (rsp_ok) begin
            r = pend.pop_front();
            if (!redirect_i && r.epoch == epoch) sb.push_back('{r.addr, r.data});
        end
        if (redirect_i) begin
            sb.delete();
            epoch++;
            exp_fetch = redirect_pc_i & ~32'h3;
        end
        if (imem_req_o && imem_gnt_i) begin
            pend.push_back('{imem_addr_o, $urandom, epoch, cyc + 1 + int'($urandom_range(max_lat))});
            if (!redirect_i) exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    task automatic phase(input int n, input int g, input int rd, input int rs, input int rr, input int lat);
        p_gnt = g; p_rdy = rd; p_rsp = rs; p_redir = rr; max_lat = lat;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic idle_inputs();
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; insn_ready_i = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req_o), 32'h0);
        chk({tag, "_valid"}, 32'(insn_valid_o), 32'h0);
        chk({tag, "_insn"}, insn_o, 32'h0);
        chk({tag, "_pc"}, pc_o, 32'h0);
    endtask

    initial begin
        idle_inputs();
        exp_fetch = BASEADDR_DEFAULT;
        #12;
        check_reset("rst");
        @(negedge clk);
        rst = 1;
        run = 1;
        phase(20, 100, 100, 100, 0, 0);
        phase(12, 100, 0, 100, 0, 0);
        phase(10, 100, 100, 100, 0, 0);
        phase(3, 100, 0, 100, 0, 2);
        p_rsp = 0;
        step(1'b1);
        phase(15, 100, 100, 100, 0, 2);
        phase(8, 0, 100, 100, 0, 0);
        phase(1500, 70, 60, 70, 5, 3);
        phase(8, 100, 0, 100, 0, 0);
        chk("pre_rst_valid", 32'(insn_valid_o), 32'h1);
        @(negedge clk);
        idle_inputs();
        #4;
        rst = 0;
        run = 0;
        #1;
        check_reset("mid_rst");
        pend.delete();
        sb.delete();
        epoch++;
        exp_fetch = BASEADDR_DEFAULT;
        @(negedge clk);
        rst = 1;
        run = 1;
        phase(400, 60, 70, 60, 6, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
